// File: rtl/idma_burst_req_queue.sv
// idma_burst_req_queue: in-order request buffer between the register frontend
// and the iDMA backend, with in-flight transfer tracking, a registered
// completion pulse per retired transfer, and an idle flag.
module idma_burst_req_queue #(
    parameter type burst_req_t    = logic,
    parameter int  Depth          = 4,
    parameter int  MaxOutstanding = 8,
    localparam int FillW          = $clog2(Depth + 1),
    localparam int OutW           = $clog2(MaxOutstanding + 1),
    localparam int PtrW           = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  burst_req_t        req_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output burst_req_t        req_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    output logic              rsp_ready_o,
    output logic              trans_complete_o,
    output logic              idle_o,
    output logic [FillW-1:0]  fill_o,
    output logic [OutW-1:0]   outstanding_o
);

    localparam logic [FillW-1:0] FillFull = FillW'(Depth);
    localparam logic [OutW-1:0]  OutFull  = OutW'(MaxOutstanding);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(Depth - 1);

    burst_req_t       r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [FillW-1:0] r_fill;
    logic [OutW-1:0]  r_outstanding;
    logic             r_complete;

    logic w_push;
    logic w_pop;
    logic w_rsp;

    // Ready/valid depend only on registered state, so there is no path from
    // req_ready_i to req_ready_o and no same-cycle fall-through.
    assign req_ready_o      = (r_fill != FillFull);
    assign req_valid_o      = (r_fill != '0) && (r_outstanding != OutFull);
    assign rsp_ready_o      = (r_outstanding != '0);
    assign req_o            = r_mem[r_rd_ptr];
    assign trans_complete_o = r_complete;
    assign idle_o           = (r_fill == '0) && (r_outstanding == '0);
    assign fill_o           = r_fill;
    assign outstanding_o    = r_outstanding;

    assign w_push = req_valid_i && req_ready_o;
    assign w_pop  = req_valid_o && req_ready_i;
    assign w_rsp  = rsp_valid_i && rsp_ready_o;

    // Storage is not reset; only pointers and fill decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= req_i;
        end
    end

    // Pointer, occupancy and in-flight bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill        <= '0;
            r_outstanding <= '0;
            r_complete    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FillW'(1);
                2'b01:   r_fill <= r_fill - FillW'(1);
                default: r_fill <= r_fill;
            endcase
            case ({w_pop, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + OutW'(1);
                2'b01:   r_outstanding <= r_outstanding - OutW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            r_complete <= w_rsp;
        end
    end

    // Simulation-only sanity checks on configuration and handshake gating.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (Depth >= 1 && MaxOutstanding >= 1)
                else $error("idma_burst_req_queue: bad parameters");
            assert (!(w_push && (r_fill == FillFull)))
                else $error("idma_burst_req_queue: push while full");
            assert (!(w_pop && (r_fill == '0)))
                else $error("idma_burst_req_queue: pop while empty");
        end
    end

endmodule

// File: tb/tb_idma_burst_req_queue.sv
// Directed bench: instance A (Depth 4, MaxOutstanding 8) and instance B
// (Depth 3, MaxOutstanding 2) share stimulus; each step checks one of them.
module tb_idma_burst_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req;
    logic        req_valid;
    logic        rdy;
    logic        rsp_valid;

    logic [63:0] a_req_o, b_req_o;
    logic        a_req_ready, b_req_ready;
    logic        a_req_valid, b_req_valid;
    logic        a_rsp_ready, b_rsp_ready;
    logic        a_tc, b_tc;
    logic        a_idle, b_idle;
    logic [2:0]  a_fill;
    logic [3:0]  a_out;
    logic [1:0]  b_fill;
    logic [1:0]  b_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idma_burst_req_queue #(
        .burst_req_t    (logic [63:0]),
        .Depth          (4),
        .MaxOutstanding (8)
    ) u_a (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (a_req_ready),
        .req_o            (a_req_o),
        .req_valid_o      (a_req_valid),
        .req_ready_i      (rdy),
        .rsp_valid_i      (rsp_valid),
        .rsp_ready_o      (a_rsp_ready),
        .trans_complete_o (a_tc),
        .idle_o           (a_idle),
        .fill_o           (a_fill),
        .outstanding_o    (a_out)
    );

    idma_burst_req_queue #(
        .burst_req_t    (logic [63:0]),
        .Depth          (3),
        .MaxOutstanding (2)
    ) u_b (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (b_req_ready),
        .req_o            (b_req_o),
        .req_valid_o      (b_req_valid),
        .req_ready_i      (rdy),
        .rsp_valid_i      (rsp_valid),
        .rsp_ready_o      (b_rsp_ready),
        .trans_complete_o (b_tc),
        .idle_o           (b_idle),
        .fill_o           (b_fill),
        .outstanding_o    (b_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    initial begin
        rst = 1'b1; req = '0; req_valid = 1'b0; rdy = 1'b0; rsp_valid = 1'b0;
        tick(); tick();
        check("rst_req_ready", 64'(a_req_ready), 64'd1);
        check("rst_req_valid", 64'(a_req_valid), 64'd0);
        check("rst_idle",      64'(a_idle),      64'd1);
        check("rst_fill",      64'(a_fill),      64'd0);
        check("rst_out",       64'(a_out),       64'd0);
        check("rst_tc",        64'(a_tc),        64'd0);
        check("rst_rsp_ready", 64'(a_rsp_ready), 64'd0);
        rst = 1'b0;

        // Latency and order: A, B, C back-to-back with backend always ready.
        rdy = 1'b1; req = 64'h1000; req_valid = 1'b1;
        check("lat_no_fallthru", 64'(a_req_valid), 64'd0);
        tick();
        check("lat_a_valid", 64'(a_req_valid), 64'd1);
        check("lat_a_data",  a_req_o,          64'h1000);
        req = 64'h2000;
        tick();
        check("ord_b_data", a_req_o,    64'h2000);
        check("ord_out1",   64'(a_out), 64'd1);
        req = 64'h3000;
        tick();
        check("ord_c_data", a_req_o,    64'h3000);
        check("ord_out2",   64'(a_out), 64'd2);
        req_valid = 1'b0;
        tick();
        check("ord_out3",   64'(a_out),       64'd3);
        check("ord_empty",  64'(a_req_valid), 64'd0);

        // Outstanding cap on B: two in flight, third held back.
        check("cap_blocked", 64'(b_req_valid), 64'd0);
        check("cap_fill",    64'(b_fill),      64'd1);
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("cap_tc",       64'(b_tc),        64'd1);
        check("cap_out1",     64'(b_out),       64'd1);
        check("cap_released", 64'(b_req_valid), 64'd1);
        check("cap_c_data",   b_req_o,          64'h3000);
        check("a_rsp_out",    64'(a_out),       64'd2);
        tick();
        check("cap_out2",     64'(b_out), 64'd2);
        check("cap_tc_once",  64'(b_tc),  64'd0);

        // Simultaneous issue and completion at outstanding 1.
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        check("sim_pre_out", 64'(a_out), 64'd1);
        req = 64'h4000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; rsp_valid = 1'b1;
        check("sim_pre_valid", 64'(a_req_valid), 64'd1);
        tick();
        rsp_valid = 1'b0;
        check("sim_out",  64'(a_out),  64'd1);
        check("sim_tc",   64'(a_tc),   64'd1);
        check("sim_fill", 64'(a_fill), 64'd0);
        tick();
        check("sim_tc_single", 64'(a_tc), 64'd0);
        rsp_valid = 1'b1;
        tick();
        check("drain_tc", 64'(a_tc), 64'd1);
        tick();
        rsp_valid = 1'b0;
        check("spurious_no_tc", 64'(a_tc),        64'd0);
        check("drain_idle",     64'(a_idle),      64'd1);
        check("drain_rsp_rdy",  64'(a_rsp_ready), 64'd0);

        // Full: five pushes into Depth 4 with the backend stalled.
        rdy = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = 64'h10 + 64'(i);
            tick();
        end
        req = 64'h14;
        check("full_fill",  64'(a_fill),      64'd4);
        check("full_ready", 64'(a_req_ready), 64'd0);
        tick();
        check("full_hold_fill", 64'(a_fill), 64'd4);
        check("full_hold_head", a_req_o,     64'h10);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("full_pop_fill",  64'(a_fill),      64'd3);
        check("full_pop_ready", 64'(a_req_ready), 64'd1);
        check("full_pop_head",  a_req_o,          64'h11);
        tick();
        req_valid = 1'b0;
        check("full_late_push", 64'(a_fill), 64'd4);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("mid_fill", 64'(a_fill), 64'd3);
        check("mid_out",  64'(a_out),  64'd2);

        // Reset mid-operation, with a completion offered in the reset cycle.
        rst = 1'b1; rsp_valid = 1'b1;
        tick();
        check("mid_rst_fill",  64'(a_fill),      64'd0);
        check("mid_rst_out",   64'(a_out),       64'd0);
        check("mid_rst_idle",  64'(a_idle),      64'd1);
        check("mid_rst_tc",    64'(a_tc),        64'd0);
        check("mid_rst_valid", 64'(a_req_valid), 64'd0);
        rst = 1'b0; rsp_valid = 1'b0;
        tick();
        check("post_rst_tc", 64'(a_tc), 64'd0);

        // Wrap: ten push/pop pairs through Depth 3 on B.
        rdy = 1'b1; rsp_valid = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req = 64'hA00 + 64'(i);
            tick();
            check("wrap_valid", 64'(b_req_valid), 64'd1);
            check("wrap_data",  b_req_o,          64'hA00 + 64'(i));
        end
        req_valid = 1'b0;
        tick();
        tick();
        rdy = 1'b0; rsp_valid = 1'b0;
        check("wrap_idle", 64'(b_idle), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
